// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard sequencer.
// Control vectors are packed in the order the pipeline registers consume them.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   typedef struct packed {
      logic pcWrite;
      logic ifidWrite;
      logic ifidFlush;
      logic idexFlush;
      logic exmemWrite;
      logic memwbBubble;
   } ctl_t;

   localparam ctl_t CTL_RUN = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0,
                                idexFlush: 1'b0, exmemWrite: 1'b1, memwbBubble: 1'b0};

   localparam ctl_t CTL_FREEZE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                   idexFlush: 1'b0, exmemWrite: 1'b0, memwbBubble: 1'b1};

   localparam ctl_t CTL_RESET = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b1,
                                  idexFlush: 1'b1, exmemWrite: 1'b0, memwbBubble: 1'b1};

   localparam logic [4:0] R0 = 5'd0;

   // $zero is never a real producer, so a load into it cannot create a hazard.
   function automatic logic loadUse(input logic       exMemread,
                                    input logic [4:0] exRt,
                                    input logic [4:0] idRs,
                                    input logic [4:0] idRt,
                                    input logic       idUsesRt);
      return exMemread && (exRt != R0) &&
             ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags the last tolerated one.
module mem_wait_timer #(
   parameter int MAX_WAIT = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_start,
   input  logic i_busy,
   output logic o_expired
);

   localparam int CW = $clog2(MAX_WAIT) + 1;

   logic [CW-1:0] r_waitCnt;

   // The freeze cycle in RUN counts as the first wait cycle, hence the reload with 1.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_waitCnt <= '0;
      end else if (i_start) begin
         r_waitCnt <= CW'(1);
      end else if (i_busy) begin
         r_waitCnt <= r_waitCnt + CW'(1);
      end
   end

   assign o_expired = (r_waitCnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes, memory freeze and hang detection.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs,
   input  logic [4:0]       i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic             i_id_jump,
   input  logic             i_ex_memread,
   input  logic [4:0]       i_ex_rt,
   input  logic             i_ex_branch_tkn,
   input  logic             i_mem_req,
   input  logic             i_dmem_ready,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_ifid_flush,
   output logic             o_idex_flush,
   output logic             o_exmem_write,
   output logic             o_memwb_bubble,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   state_t r_state;
   state_t w_stateNext;
   ctl_t   w_ctl;
   ctl_t   w_hazardCtl;
   logic   w_start;
   logic   w_busy;
   logic   w_expired;
   logic   r_memTimeout;

   mem_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (w_start),
      .i_busy    (w_busy),
      .o_expired (w_expired)
   );

   // Branch squashes the ID instruction, so it outranks the load-use stall.
   always_comb begin
      w_hazardCtl = CTL_RUN;
      if (i_ex_branch_tkn) begin
         w_hazardCtl.ifidFlush = 1'b1;
         w_hazardCtl.idexFlush = 1'b1;
      end else if (loadUse(i_ex_memread, i_ex_rt, i_id_rs, i_id_rt, i_id_uses_rt)) begin
         w_hazardCtl.pcWrite   = 1'b0;
         w_hazardCtl.ifidWrite = 1'b0;
         w_hazardCtl.idexFlush = 1'b1;
      end else if (i_id_jump) begin
         w_hazardCtl.ifidFlush = 1'b1;
      end
   end

   always_comb begin
      w_ctl       = CTL_RUN;
      w_stateNext = r_state;
      w_start     = 1'b0;
      w_busy      = 1'b0;
      if (i_reset) begin
         w_ctl = CTL_RESET;
      end else begin
         case (r_state)
            RUN: begin
               if (i_mem_req && !i_dmem_ready) begin
                  w_ctl       = CTL_FREEZE;
                  w_start     = 1'b1;
                  w_stateNext = MEM_WAIT;
               end else begin
                  w_ctl = w_hazardCtl;
               end
            end
            MEM_WAIT: begin
               if (!i_dmem_ready) begin
                  w_ctl  = CTL_FREEZE;
                  w_busy = 1'b1;
                  if (w_expired) begin
                     w_stateNext = HALT;
                  end
               end else begin
                  // Release is zero-cycle: pending hazards are evaluated right away.
                  w_ctl       = w_hazardCtl;
                  w_stateNext = RUN;
               end
            end
            HALT: begin
               w_ctl = CTL_FREEZE;
            end
            default: begin
               w_ctl       = CTL_FREEZE;
               w_stateNext = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= RUN;
         r_memTimeout <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_stateNext == HALT) begin
            r_memTimeout <= 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   // Both counters saturate rather than wrap so long runs stay meaningful.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if ((r_state != HALT) && !w_ctl.pcWrite && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_ctl.ifidFlush && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign o_stall_cnt = r_stallCnt;
   assign o_flush_cnt = r_flushCnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

   assign o_pc_write     = w_ctl.pcWrite;
   assign o_ifid_write   = w_ctl.ifidWrite;
   assign o_ifid_flush   = w_ctl.ifidFlush;
   assign o_idex_flush   = w_ctl.idexFlush;
   assign o_exmem_write  = w_ctl.exmemWrite;
   assign o_memwb_bubble = w_ctl.memwbBubble;
   assign o_mem_timeout  = r_memTimeout;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios then randomized traffic.
// Expected responses come from a cycle-level behavioural model of the pipeline rules.
module tb_hazard_sequencer;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 32;

   // Control vector order: {pc, ifidW, ifidF, idexF, exmemW, bubble}
   localparam logic [5:0] E_RUN    = 6'b110010;
   localparam logic [5:0] E_FREEZE = 6'b000001;
   localparam logic [5:0] E_RESET  = 6'b001101;
   localparam logic [5:0] E_BRANCH = 6'b111110;
   localparam logic [5:0] E_STALL  = 6'b000110;
   localparam logic [5:0] E_JUMP   = 6'b111010;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       idRs, idRt, exRt;
   logic             idUsesRt, idJump, exMemread, exBranchTkn, memReq, dmemReady;
   logic             pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memwbBubble;
   logic             memTimeout;
   logic [CNT_W-1:0] stallCnt, flushCnt;

   typedef struct {
      logic [5:0]       ctl;
      logic             timeout;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } exp_t;

   exp_t scoreQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   bit               mWaiting = 0;
   int               mNotReady = 0;
   bit               mHalted = 0;
   bit               mTimeout = 0;
   logic [CNT_W-1:0] mStall = '0;
   logic [CNT_W-1:0] mFlush = '0;

   always #5 clk = ~clk;

   hazard_sequencer #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_id_rs         (idRs),
      .i_id_rt         (idRt),
      .i_id_uses_rt    (idUsesRt),
      .i_id_jump       (idJump),
      .i_ex_memread    (exMemread),
      .i_ex_rt         (exRt),
      .i_ex_branch_tkn (exBranchTkn),
      .i_mem_req       (memReq),
      .i_dmem_ready    (dmemReady),
      .o_pc_write      (pcWrite),
      .o_ifid_write    (ifidWrite),
      .o_ifid_flush    (ifidFlush),
      .o_idex_flush    (idexFlush),
      .o_exmem_write   (exmemWrite),
      .o_memwb_bubble  (memwbBubble),
      .o_mem_timeout   (memTimeout),
      .o_stall_cnt     (stallCnt),
      .o_flush_cnt     (flushCnt)
   );

   // Drives one cycle of inputs, predicts the response and advances the model.
   task automatic applyStimulus(input logic aRst, input logic aMemReq, input logic aReady,
                                input logic aBranch, input logic aMemread, input logic [4:0] aExRt,
                                input logic [4:0] aIdRs, input logic [4:0] aIdRt,
                                input logic aUsesRt, input logic aJump);
      exp_t       e;
      logic [5:0] ctl;
      bit         frozen;
      bit         hazard;
      @(negedge clk);
      reset = aRst; memReq = aMemReq; dmemReady = aReady; exBranchTkn = aBranch;
      exMemread = aMemread; exRt = aExRt; idRs = aIdRs; idRt = aIdRt;
      idUsesRt = aUsesRt; idJump = aJump;

      frozen = !aRst && !mHalted && !aReady && (mWaiting || aMemReq);
      hazard = aMemread && (aExRt != 5'd0) && ((aExRt == aIdRs) || (aUsesRt && (aExRt == aIdRt)));
      if (aRst)                  ctl = E_RESET;
      else if (mHalted || frozen) ctl = E_FREEZE;
      else if (aBranch)          ctl = E_BRANCH;
      else if (hazard)           ctl = E_STALL;
      else if (aJump)            ctl = E_JUMP;
      else                       ctl = E_RUN;

      e.ctl = ctl;
      e.timeout = mTimeout;
`ifdef HAZARD_STATS_EN
      e.stall = mStall;
      e.flush = mFlush;
`else
      e.stall = '0;
      e.flush = '0;
`endif
      scoreQ.push_back(e);

      if (aRst) begin
         mWaiting = 0; mNotReady = 0; mHalted = 0; mTimeout = 0;
         mStall = '0; mFlush = '0;
      end else begin
         if (!mHalted && !ctl[5] && mStall != '1) mStall = mStall + 1;
         if (ctl[3] && mFlush != '1) mFlush = mFlush + 1;
         if (!mHalted) begin
            if (frozen) begin
               mWaiting = 1;
               mNotReady++;
               if (mNotReady >= MAX_WAIT) begin
                  mHalted = 1;
                  mTimeout = 1;
               end
            end else begin
               mWaiting = 0;
               mNotReady = 0;
            end
         end
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [5:0] got;
      got = {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memwbBubble};
      testsRun++;
      if (got !== e.ctl) begin
         testsFailed++;
         $display("[TB] FAIL ctl @%0t: got %b expected %b", $time, got, e.ctl);
      end
      testsRun++;
      if (memTimeout !== e.timeout) begin
         testsFailed++;
         $display("[TB] FAIL mem_timeout @%0t: got %b expected %b", $time, memTimeout, e.timeout);
      end
      testsRun++;
      if (stallCnt !== e.stall) begin
         testsFailed++;
         $display("[TB] FAIL stall_cnt @%0t: got %0d expected %0d", $time, stallCnt, e.stall);
      end
      testsRun++;
      if (flushCnt !== e.flush) begin
         testsFailed++;
         $display("[TB] FAIL flush_cnt @%0t: got %0d expected %0d", $time, flushCnt, e.flush);
      end
   endtask

   // Monitor: the outputs are valid every cycle, so one entry is consumed per cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
   endtask

   initial begin
      int stuck;
      int guard;
      logic rRst, rReq, rRdy, rBr, rMr, rUses, rJmp;
      reset = 1'b1; memReq = 0; dmemReady = 1; exBranchTkn = 0; exMemread = 0;
      exRt = 0; idRs = 0; idRt = 0; idUsesRt = 0; idJump = 0;
      repeat (2) @(posedge clk);

      // Reset held three cycles, then a quiet cycle
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(1);

      // Load-use on rs, then the same with a load into $zero
      applyStimulus(0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd3, 1, 0);
      idle(1);
      applyStimulus(0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
      applyStimulus(0, 0, 1, 0, 1, 5'd9, 5'd4, 5'd9, 1, 0);
      applyStimulus(0, 0, 1, 0, 1, 5'd9, 5'd4, 5'd9, 0, 0);
      // Load-use with a jr in ID, then the jump on the following cycle
      applyStimulus(0, 0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd7, 5'd0, 0, 1);

      // Memory wait of three cycles then release
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      idle(1);

      // Branch together with load-use
      applyStimulus(0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 0);

      // Branch while frozen flushes only in the release cycle
      for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      idle(1);

      // Hung memory: halt, sticky timeout, ready ignored until reset
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1);
      applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(2);

      // Randomized traffic with occasional stuck-memory bursts and resets
      stuck = 0;
      for (int i = 0; i < 3000; i++) begin
         if (stuck == 0 && $urandom_range(0, 29) == 0) stuck = $urandom_range(1, 6);
         rRst  = ($urandom_range(0, 79) == 0);
         rReq  = ($urandom_range(0, 9) < 3);
         rRdy  = (stuck > 0) ? 1'b0 : ($urandom_range(0, 9) != 0);
         rBr   = ($urandom_range(0, 9) == 0);
         rMr   = ($urandom_range(0, 2) == 0);
         rUses = $urandom_range(0, 1);
         rJmp  = ($urandom_range(0, 7) == 0);
         applyStimulus(rRst, rReq, rRdy, rBr, rMr, 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rUses, rJmp);
         if (stuck > 0) stuck--;
      end

      guard = 0;
      while (scoreQ.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      #5;
      if (scoreQ.size() > 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", scoreQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
